// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared state type and sizing helpers for the SPI slave.
package spi_slave_pkg;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_e;

    function automatic int unsigned bit_cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

    function automatic logic [63:0] underrun_word(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SyncStages-flop pin synchroniser with optional edge detection
// relative to the pin's idle level (Idle is also the reset value).
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter bit          Idle       = 1'b0,
    parameter bit          EdgeEn     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic lead_o,
    output logic trail_o
);

    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= {SyncStages{Idle}};
        else         sync_q <= {sync_q[SyncStages-2:0], d_i};
    end

    assign q_o = sync_q[SyncStages-1];

    if (EdgeEn) begin : g_edge
        logic dly_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) dly_q <= Idle;
            else         dly_q <= q_o;
        end
        assign lead_o  = (q_o != Idle) && (dly_q == Idle);
        assign trail_o = (q_o == Idle) && (dly_q != Idle);
    end else begin : g_no_edge
        assign lead_o  = 1'b0;
        assign trail_o = 1'b0;
    end

endmodule

// File: rtl/spi_slave_duplex.sv
// spi_slave_duplex: full-duplex SPI slave for any CPOL/CPHA mode.
// The MISO transmit path is built only when SPI_SLAVE_TX_EN is defined.
module spi_slave_duplex
    import spi_slave_pkg::*;
#(
    parameter int unsigned DataWidth  = 8,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0,
    parameter int unsigned SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 spi_sclk_i,
    input  logic                 spi_cs_ni,
    input  logic                 spi_mosi_i,
    output logic                 spi_miso_o,
    output logic                 spi_miso_oe_o,
    output logic [DataWidth-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    input  logic [DataWidth-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 rx_overrun_o,
    output logic                 tx_underrun_o,
    output logic                 frame_abort_o,
    output logic                 busy_o
);

    localparam int unsigned    CntW    = bit_cnt_width(DataWidth);
    localparam logic [CntW-1:0] LastBit = CntW'(DataWidth - 1);

    logic sclk_lead, sclk_trail, cs_n_s, mosi_s;
    logic unused_sclk_s, unused_cs_lead, unused_cs_trail, unused_mosi_lead, unused_mosi_trail;

    spi_sync_edge #(.SyncStages(SyncStages), .Idle(CPOL), .EdgeEn(1'b1)) u_sync_sclk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (spi_sclk_i),
        .q_o     (unused_sclk_s),
        .lead_o  (sclk_lead),
        .trail_o (sclk_trail)
    );

    spi_sync_edge #(.SyncStages(SyncStages), .Idle(1'b1), .EdgeEn(1'b0)) u_sync_cs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (spi_cs_ni),
        .q_o     (cs_n_s),
        .lead_o  (unused_cs_lead),
        .trail_o (unused_cs_trail)
    );

    spi_sync_edge #(.SyncStages(SyncStages), .Idle(1'b0), .EdgeEn(1'b0)) u_sync_mosi (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (spi_mosi_i),
        .q_o     (mosi_s),
        .lead_o  (unused_mosi_lead),
        .trail_o (unused_mosi_trail)
    );

    spi_state_e           state_q, state_d;
    logic [CntW-1:0]      bit_cnt_q;
    logic [DataWidth-1:0] rx_shift_q, rx_word;
    logic entry, leave, sample, shift, word_done, rx_take;

    // CS release wins over any SCLK edge seen in the same cycle
    always_comb begin
        entry     = (state_q == SPI_IDLE) && !cs_n_s;
        leave     = (state_q == SPI_ACTIVE) && cs_n_s;
        sample    = (state_q == SPI_ACTIVE) && !cs_n_s && (CPHA ? sclk_trail : sclk_lead);
        shift     = (state_q == SPI_ACTIVE) && !cs_n_s && (CPHA ? sclk_lead : sclk_trail);
        word_done = sample && (bit_cnt_q == LastBit);
        rx_take   = word_done && (!rx_valid_o || rx_ready_i);
        rx_word   = {rx_shift_q[DataWidth-2:0], mosi_s};
        state_d   = entry ? SPI_ACTIVE : leave ? SPI_IDLE : state_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= SPI_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            rx_overrun_o  <= 1'b0;
            frame_abort_o <= 1'b0;
        end else begin
            rx_overrun_o  <= word_done && !rx_take;
            frame_abort_o <= leave && (bit_cnt_q != '0);
            bit_cnt_q     <= (entry || leave || word_done) ? '0 :
                             sample ? bit_cnt_q + CntW'(1) : bit_cnt_q;
            rx_shift_q    <= sample ? rx_word : rx_shift_q;
            rx_data_o     <= rx_take ? rx_word : rx_data_o;
            rx_valid_o    <= rx_take || (rx_valid_o && !rx_ready_i);
        end
    end

    assign busy_o = (state_q == SPI_ACTIVE);

`ifdef SPI_SLAVE_TX_EN
    localparam logic [DataWidth-1:0] AllOnes = DataWidth'(underrun_word(DataWidth));

    logic [DataWidth-1:0] tx_shift_q;
    logic                 reload_q, load;

    // CPHA=0 reloads on the first shift edge after a completed word; CPHA=1 at each word start
    assign load = entry || (shift && (CPHA ? (bit_cnt_q == '0) : reload_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_shift_q    <= '0;
            reload_q      <= 1'b0;
            tx_ready_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            tx_ready_o    <= load && tx_valid_i;
            tx_underrun_o <= load && !tx_valid_i;
            tx_shift_q    <= load ? (tx_valid_i ? tx_data_i : AllOnes) :
                             shift ? {tx_shift_q[DataWidth-2:0], 1'b0} : tx_shift_q;
            reload_q      <= (entry || load) ? 1'b0 : word_done ? 1'b1 : reload_q;
        end
    end

    assign spi_miso_o    = tx_shift_q[DataWidth-1];
    assign spi_miso_oe_o = busy_o;
`else
    logic unused_tx;
    assign unused_tx     = ^{tx_data_i, tx_valid_i, shift};
    assign spi_miso_o    = 1'b0;
    assign spi_miso_oe_o = 1'b0;
    assign tx_ready_o    = 1'b0;
    assign tx_underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_duplex.sv
// tb_spi_slave_duplex: two DUTs (8-bit mode 0, 16-bit mode 3) driven by a bit-banged SPI master.
module tb_spi_slave_duplex;

`ifdef SPI_SLAVE_TX_EN
    localparam bit TxEn = 1'b1;
`else
    localparam bit TxEn = 1'b0;
`endif
    localparam int Half = 8;
    localparam int Gap  = 12;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    logic       a_sclk, a_cs_n, a_mosi, a_miso, a_oe, a_rx_valid, a_rx_ready, a_tx_valid, a_tx_ready;
    logic       a_ovr, a_und, a_abort, a_busy;
    logic [7:0] a_rx_data, a_tx_data;
    logic        b_sclk, b_cs_n, b_mosi, b_miso, b_oe, b_rx_valid, b_rx_ready, b_tx_valid, b_tx_ready;
    logic        b_ovr, b_und, b_abort, b_busy;
    logic [15:0] b_rx_data, b_tx_data;

    spi_slave_duplex #(.DataWidth(8), .CPOL(1'b0), .CPHA(1'b0), .SyncStages(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .spi_sclk_i(a_sclk), .spi_cs_ni(a_cs_n), .spi_mosi_i(a_mosi),
        .spi_miso_o(a_miso), .spi_miso_oe_o(a_oe), .rx_data_o(a_rx_data), .rx_valid_o(a_rx_valid),
        .rx_ready_i(a_rx_ready), .tx_data_i(a_tx_data), .tx_valid_i(a_tx_valid), .tx_ready_o(a_tx_ready),
        .rx_overrun_o(a_ovr), .tx_underrun_o(a_und), .frame_abort_o(a_abort), .busy_o(a_busy)
    );

    spi_slave_duplex #(.DataWidth(16), .CPOL(1'b1), .CPHA(1'b1), .SyncStages(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .spi_sclk_i(b_sclk), .spi_cs_ni(b_cs_n), .spi_mosi_i(b_mosi),
        .spi_miso_o(b_miso), .spi_miso_oe_o(b_oe), .rx_data_o(b_rx_data), .rx_valid_o(b_rx_valid),
        .rx_ready_i(b_rx_ready), .tx_data_i(b_tx_data), .tx_valid_i(b_tx_valid), .tx_ready_o(b_tx_ready),
        .rx_overrun_o(b_ovr), .tx_underrun_o(b_und), .frame_abort_o(b_abort), .busy_o(b_busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0]  a_exp_q[$];
    logic [15:0] b_exp_q[$];
    logic [7:0]  a_tx_q[$];
    int a_pops = 0, a_rdy = 0, a_undc = 0, a_ovrc = 0, a_abt = 0, a_oe_cyc = 0, a_busy_cyc = 0;
    int b_pops = 0, b_abt = 0, b_oe_cyc = 0;

    // Scoreboard: every RX handshake pops the oldest expected word; the TX source feeds from a_tx_q.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (a_rx_valid && a_rx_ready) begin
                a_pops++;
                if (a_exp_q.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL a_rx_unexpected: got %h, expected no word", a_rx_data);
                end else check("a_rx_data", 32'(a_rx_data), 32'(a_exp_q.pop_front()));
            end
            if (b_rx_valid && b_rx_ready) begin
                b_pops++;
                if (b_exp_q.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL b_rx_unexpected: got %h, expected no word", b_rx_data);
                end else check("b_rx_data", 32'(b_rx_data), 32'(b_exp_q.pop_front()));
            end
            a_rdy      += int'(a_tx_ready);
            a_undc     += int'(a_und);
            a_ovrc     += int'(a_ovr);
            a_abt      += int'(a_abort);
            a_oe_cyc   += int'(a_oe);
            a_busy_cyc += int'(a_busy);
            b_abt      += int'(b_abort);
            b_oe_cyc   += int'(b_oe);
            if (a_tx_ready && a_tx_q.size() > 0) void'(a_tx_q.pop_front());
        end
        a_tx_valid = a_tx_q.size() > 0;
        a_tx_data  = a_tx_valid ? a_tx_q[0] : 8'h00;
    end

    task automatic set_pins(input bit b, input logic sclk, input logic cs_n, input logic mosi);
        if (b) begin b_sclk = sclk; b_cs_n = cs_n; b_mosi = mosi; end
        else   begin a_sclk = sclk; a_cs_n = cs_n; a_mosi = mosi; end
    endtask

    // Mode 0 master raises CS together with the last trailing edge unless cs_late is set.
    task automatic spi_frame(input bit b, input logic [31:0] mosi, input int nbits,
                             input bit cs_late, output logic [31:0] miso);
        logic pol;
        pol  = b;
        miso = '0;
        set_pins(b, pol, 1'b0, b ? 1'b0 : mosi[nbits-1]);
        wait_clk(Half);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!b) begin
                miso = {miso[30:0], a_miso};
                a_sclk = 1'b1;
                wait_clk(Half);
                a_sclk = 1'b0;
                if (i > 0) a_mosi = mosi[i-1];
                else if (!cs_late) a_cs_n = 1'b1;
                wait_clk(Half);
            end else begin
                b_sclk = 1'b0;
                b_mosi = mosi[i];
                wait_clk(Half);
                miso = {miso[30:0], b_miso};
                b_sclk = 1'b1;
                wait_clk(Half);
            end
        end
        set_pins(b, pol, 1'b1, 1'b0);
        wait_clk(Gap);
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        bit         tx_valid;
        logic [7:0] miso;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [31:0] miso;
        int r0, u0, o0, f0, p0;
        vecs[0] = '{mosi: 8'hA5, tx: 8'h3C, tx_valid: 1'b1, miso: 8'h3C};
        vecs[1] = '{mosi: 8'h81, tx: 8'h00, tx_valid: 1'b0, miso: 8'hFF};
        vecs[2] = '{mosi: 8'h00, tx: 8'hFF, tx_valid: 1'b1, miso: 8'hFF};
        vecs[3] = '{mosi: 8'h5C, tx: 8'hA7, tx_valid: 1'b1, miso: 8'hA7};

        rst_ni = 1'b0;
        set_pins(1'b0, 1'b0, 1'b1, 1'b0);
        set_pins(1'b1, 1'b1, 1'b1, 1'b0);
        a_rx_ready = 1'b1; b_rx_ready = 1'b1;
        b_tx_valid = 1'b1; b_tx_data = 16'h1234;
        wait_clk(4);
        check("reset_a", {a_rx_data, a_rx_valid, a_miso, a_oe, a_busy, a_tx_ready, a_ovr, a_und, a_abort}, '0);
        check("reset_b", {b_rx_data, b_rx_valid, b_miso, b_oe, b_busy, b_tx_ready, b_ovr, b_und, b_abort}, '0);
        rst_ni = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 4; i++) begin
            r0 = a_rdy; u0 = a_undc; f0 = a_abt;
            if (vecs[i].tx_valid) a_tx_q.push_back(vecs[i].tx);
            a_exp_q.push_back(vecs[i].mosi);
            spi_frame(1'b0, 32'(vecs[i].mosi), 8, 1'b0, miso);
            check($sformatf("vec%0d_miso", i), miso, TxEn ? 32'(vecs[i].miso) : 32'h0);
            check($sformatf("vec%0d_tx_ready", i), a_rdy - r0, TxEn ? 32'(vecs[i].tx_valid) : 32'h0);
            check($sformatf("vec%0d_underrun", i), a_undc - u0, TxEn ? 32'(!vecs[i].tx_valid) : 32'h0);
            check($sformatf("vec%0d_abort", i), a_abt - f0, 0);
            check($sformatf("vec%0d_rx_pending", i), a_exp_q.size(), 0);
            a_tx_q.delete();
        end

        r0 = a_rdy; u0 = a_undc;
        a_tx_q.push_back(8'hC3); a_tx_q.push_back(8'h5A);
        a_exp_q.push_back(8'h12); a_exp_q.push_back(8'h34);
        spi_frame(1'b0, 32'h1234, 16, 1'b0, miso);
        check("b2b_miso", miso, TxEn ? 32'hC35A : 32'h0);
        check("b2b_tx_ready", a_rdy - r0, TxEn ? 32'd2 : 32'd0);
        check("b2b_underrun", a_undc - u0, 0);
        check("b2b_rx_pending", a_exp_q.size(), 0);

        o0 = a_ovrc; u0 = a_undc; a_rx_ready = 1'b0;
        a_tx_q.delete();
        spi_frame(1'b0, 32'h010203, 24, 1'b0, miso);
        check("ovr_rx_data", {a_rx_valid, a_rx_data}, {1'b1, 8'h01});
        check("ovr_pulses", a_ovrc - o0, 2);
        check("ovr_underrun", a_undc - u0, TxEn ? 32'd3 : 32'd0);
        check("ovr_miso", miso, TxEn ? 32'hFFFFFF : 32'h0);
        a_exp_q.push_back(8'h01);
        a_rx_ready = 1'b1;
        wait_clk(2);
        check("ovr_drain", {a_exp_q.size() != 0, a_rx_valid}, 0);

        f0 = a_abt; p0 = a_pops;
        spi_frame(1'b0, 32'h1E, 5, 1'b1, miso);
        check("abort_pulse", a_abt - f0, 1);
        check("abort_no_rx", a_pops - p0, 0);
        a_exp_q.push_back(8'h81);
        spi_frame(1'b0, 32'h81, 8, 1'b0, miso);
        check("after_abort_rx_pending", a_exp_q.size(), 0);
        check("after_abort_rx_data", a_rx_data, 8'h81);

        f0 = b_abt;
        b_exp_q.push_back(16'hBEEF);
        spi_frame(1'b1, 32'hBEEF, 16, 1'b1, miso);
        check("b_miso", miso, TxEn ? 32'h1234 : 32'h0);
        check("b_rx_pending", b_exp_q.size(), 0);
        check("b_rx_data", b_rx_data, 16'hBEEF);
        check("b_oe_seen", b_oe_cyc != 0, TxEn);
        check("b_abort", b_abt - f0, 0);
        check("a_oe_seen", a_oe_cyc != 0, TxEn);
        check("a_busy_seen", a_busy_cyc != 0, 1);

        a_cs_n = 1'b0;
        wait_clk(Half);
        check("busy_before_reset", a_busy, 1);
        #3 rst_ni = 1'b0;
        #1 check("async_reset", {a_busy, a_oe, a_miso, a_rx_valid, a_rx_data, b_rx_data}, '0);
        a_cs_n = 1'b1;
        wait_clk(3);
        rst_ni = 1'b1;
        wait_clk(4);
        a_tx_q.push_back(8'h9C);
        a_exp_q.push_back(8'h3E);
        spi_frame(1'b0, 32'h3E, 8, 1'b0, miso);
        check("recover_miso", miso, TxEn ? 32'h9C : 32'h0);
        check("recover_rx_pending", a_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_duplex.md
# spi_slave_duplex

Parametrised full-duplex SPI slave and the next generation of our receive-only SPI slave.
- Receives DataWidth-bit words on MOSI and shifts out words from a valid/ready TX interface on MISO, in any CPOL/CPHA mode.
- Synchronises the SPI pins into clk_i and reports overrun, underrun and aborted frames.
- Sits between the demo-system SPI pins and a bus-side FIFO or register block.

## Interface
- DataWidth, 8: bits per SPI word, ≥ 2; MSB first.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 samples MOSI on the leading edge; 1 samples on the trailing edge.
- SyncStages, 2: flops per pin synchroniser, ≥ 2.
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- spi_sclk_i / spi_cs_ni / spi_mosi_i  in  1 each  raw pins.
- spi_miso_o  out  1  serial data out.
- spi_miso_oe_o  out  1  MISO output enable.
- rx_data_o  out  DataWidth  last completed RX word.
- rx_valid_o  out  1  RX word pending.
- rx_ready_i  in  1  consumer accepts rx_data_o.
- tx_data_i  in  DataWidth  next word to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  single-cycle pulse: tx_data_i consumed.
- rx_overrun_o / tx_underrun_o / frame_abort_o  out  1 each  single-cycle status pulses.
- busy_o  out  1  high while in ACTIVE.

## Operation
- sclk, cs_n and mosi each pass a SyncStages synchroniser. sclk_q is the synchronised SCLK delayed by one more flop.
- Leading edge: synchronised SCLK leaves CPOL while sclk_q == CPOL. Trailing edge is the reverse.
- Sample edge = leading if CPHA=0, else trailing. Shift edge = the other.
- FSM, state in a register:
  - IDLE → ACTIVE when synchronised cs_n is low. On entry: bit_cnt=0; TX load (below).
  - ACTIVE → IDLE when synchronised cs_n is high, with priority over any edge in the same cycle.
- RX:
  - On each sample edge, rx_shift = {rx_shift[DataWidth-2:0], mosi}; bit_cnt increments.
  - When bit_cnt == DataWidth-1 on a sample edge, the word completes and bit_cnt wraps to 0.
  - If rx_valid_o is low or rx_ready_i is high that cycle: rx_data_o ← completed word; rx_valid_o=1.
  - Otherwise the new word is dropped, rx_data_o is held, and rx_overrun_o pulses.
  - rx_valid_o clears on the cycle rx_valid_o && rx_ready_i, unless a word completes in that same cycle.
- TX:
  - spi_miso_o = tx_shift[DataWidth-1].
  - A load takes tx_data_i and pulses tx_ready_o if tx_valid_i is high. Otherwise it loads all-ones and pulses tx_underrun_o.
  - CPHA=0: load on ACTIVE entry and on the first shift edge after a word completes. All other shift edges shift left, filling with 0.
  - CPHA=1: load on ACTIVE entry and on each shift edge with bit_cnt==0. All other shift edges shift left.
- CS deassert with bit_cnt ≠ 0:
  - The partial word is discarded and rx_data_o/rx_valid_o are unchanged.
  - frame_abort_o pulses and bit_cnt resets to 0.
- spi_miso_oe_o = (state==ACTIVE).

## Timing
- Reset values:
  - Outputs: all low or 0, including rx_data_o=0 and spi_miso_o=0.
  - Internal: state=IDLE; synchroniser flops reset to cs_n=1 and sclk=CPOL.
- Pin-to-internal latency is SyncStages cycles. The edge is detected combinationally on the next cycle.
- rx_valid_o rises SyncStages+1 clk_i cycles after the first clk_i edge that captures the final sample SCLK edge.
- spi_miso_o changes SyncStages+1 cycles after the shift-edge capture.
- The master must keep SCLK high and low phases ≥ SyncStages+3 clk_i cycles.
- The master must allow ≥ SyncStages+3 cycles from CS fall to the first SCLK edge. This lets the MSB settle for CPHA=0.
- All status pulses last exactly one cycle. Several status pulses may assert in the same cycle.
- Async reset mid-frame returns every register to its reset value immediately. The frame resumes only after the next CS assertion.

## Configuration
- SPI_SLAVE_TX_EN defined: the TX path is built as described.
- Undefined: the TX shift register and load logic are removed. The ports remain and are driven as follows:
  - spi_miso_o=0, spi_miso_oe_o=0, tx_ready_o=0, tx_underrun_o=0.
  - tx_data_i and tx_valid_i are ignored.
  - RX behaviour is unchanged.

## Structure
- spi_slave_pkg holds:
  - the state enum (SPI_IDLE, SPI_ACTIVE);
  - a function computing bit_cnt width, $clog2(DataWidth);
  - the all-ones underrun constant as a function of width.
- One sub-module, spi_sync_edge: a SyncStages synchroniser plus optional edge detector, instantiated once per pin. The edge detector is used for SCLK only.

## Test plan
- DataWidth=8, CPOL=0, CPHA=0. MOSI 0xA5 with tx 0x3C preloaded → rx_data_o=0xA5, rx_valid_o high; MISO bits 0,0,1,1,1,1,0,0; one tx_ready_o pulse.
- Same mode, two back-to-back words 0x12, 0x34 with tx 0xC3, 0x5A, rx_ready_i=1 → two rx_valid_o events with 0x12 then 0x34; MISO shows 0xC3 then 0x5A.
- rx_ready_i=0, three words 0x01, 0x02, 0x03 → rx_data_o stays 0x01; rx_overrun_o pulses twice.
- tx_valid_i=0 for a whole frame → MISO all ones (0xFF); tx_underrun_o pulses once.
- CS raised after 5 bits of 0xF0 → no rx_valid_o, one frame_abort_o pulse. The next full frame 0x81 → rx_data_o=0x81.
- DataWidth=16, CPOL=1, CPHA=1. MOSI 0xBEEF with tx 0x1234 → rx_data_o=0xBEEF, MISO 0x1234. Rebuild without SPI_SLAVE_TX_EN → spi_miso_oe_o stays 0 and rx_data_o is still 0xBEEF.
